// File: rtl/flappy_io_pkg.sv
// ---------------------------------------------------------------------------
// flappy_io_pkg
// Shared definitions for the flappy MMIO input port:
//   io_addr_t      CPU register select (STATUS, FRAME, FLAPS, ID)
//   ST_*           bit positions inside the STATUS register
//   deb_state_t    button debouncer FSM states
// ---------------------------------------------------------------------------
package flappy_io_pkg;

  typedef enum logic [1:0] {
    ADDR_STATUS = 2'd0,
    ADDR_FRAME  = 2'd1,
    ADDR_FLAPS  = 2'd2,
    ADDR_ID     = 2'd3
  } io_addr_t;

  localparam int ST_FLAP  = 0;
  localparam int ST_LEVEL = 1;
  localparam int ST_FRAME = 2;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw asynchronous push-button into the clock domain with two
// flops, then requires DEBOUNCE_CYCLES of stable level before the debounced
// level changes. A single-cycle press pulse marks each accepted rising edge.
// Ports:
//   clock   in   system clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   raw_in  in   raw button pin, high = pressed
//   level   out  debounced button level
//   press   out  one-cycle pulse when a press is accepted
// ---------------------------------------------------------------------------
module button_debouncer
  import flappy_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  deb_state_t       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_press;

  // Two-flop synchroniser; nothing else is allowed to see raw_in.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic. The press pulse is emitted in the last qualifying
  // cycle of S_RISE, so it coincides with the transition into S_HIGH and
  // can only occur once per stable high period.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_press      = 1'b0;
    case (r_state)
      S_LOW: begin
        if (r_sync2) begin
          w_next_state = S_RISE;
          w_next_cnt   = '0;
        end
      end
      S_RISE: begin
        if (!r_sync2) begin
          w_next_state = S_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_HIGH;
          w_press      = 1'b1;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!r_sync2) begin
          w_next_state = S_FALL;
          w_next_cnt   = '0;
        end
      end
      S_FALL: begin
        if (r_sync2) begin
          w_next_state = S_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_LOW;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_LOW;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign press = w_press;
  assign level = (r_state == S_HIGH) || (r_state == S_FALL);

endmodule

// File: rtl/mmio_input_port.sv
// ---------------------------------------------------------------------------
// mmio_input_port
// CPU-facing read-only MMIO block. Debounces the flap button, latches flap
// and frame events as sticky flags, counts them, and serves registered reads.
// Reading STATUS clears both sticky flags (an event in the same cycle wins).
// Ports:
//   clock        in   system clock
//   rst          in   synchronous active-high reset
//   btn_flap     in   raw asynchronous push-button
//   frame_start  in   one-cycle pulse at start of vblank
//   rd_en        in   read strobe, one cycle per access
//   rd_addr      in   register select (io_addr_t)
//   rd_data      out  read data, valid while rd_valid=1, held otherwise
//   rd_valid     out  high one cycle after each rd_en
// ---------------------------------------------------------------------------
module mmio_input_port
  import flappy_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [31:0] ID_VALUE        = 32'hF1A9_0001
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        btn_flap,
  input  logic        frame_start,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  logic        w_level;
  logic        w_press;
  logic        w_status_rd;
  logic [31:0] w_rd_mux;

  logic        r_flap_pending;
  logic        r_frame_pending;
  logic [15:0] r_flap_count;
  logic [31:0] r_frame_count;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (clock),
    .rst   (rst),
    .raw_in(btn_flap),
    .level (w_level),
    .press (w_press)
  );

  assign w_status_rd = rd_en && (io_addr_t'(rd_addr) == ADDR_STATUS);

  // Sticky flags: an event in the clearing cycle keeps the flag set so the
  // following STATUS read still reports it.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_flap_pending  <= 1'b0;
      r_frame_pending <= 1'b0;
    end else begin
      if (w_press)          r_flap_pending <= 1'b1;
      else if (w_status_rd) r_flap_pending <= 1'b0;
      if (frame_start)      r_frame_pending <= 1'b1;
      else if (w_status_rd) r_frame_pending <= 1'b0;
    end
  end

  // Event counters: flap count saturates, frame count wraps.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_flap_count  <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_press && (r_flap_count != 16'hFFFF))
        r_flap_count <= r_flap_count + 16'd1;
      if (frame_start)
        r_frame_count <= r_frame_count + 32'd1;
    end
  end

  // Read mux samples the pre-update values of this cycle.
  always_comb begin
    w_rd_mux = '0;
    case (io_addr_t'(rd_addr))
      ADDR_STATUS: begin
        w_rd_mux[ST_FLAP]  = r_flap_pending;
        w_rd_mux[ST_LEVEL] = w_level;
        w_rd_mux[ST_FRAME] = r_frame_pending;
      end
      ADDR_FRAME:  w_rd_mux = r_frame_count;
      ADDR_FLAPS:  w_rd_mux = {16'b0, r_flap_count};
      ADDR_ID:     w_rd_mux = ID_VALUE;
      default:     w_rd_mux = '0;
    endcase
  end

  // Read response register; data holds between accesses.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  // A read whose response cycle coincides with rst being raised is dropped,
  // so in-flight reads never complete once reset is asserted.
  assign rd_valid = r_rd_valid && !rst;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_mmio_input_port.sv
// ---------------------------------------------------------------------------
// tb_mmio_input_port
// Directed bench for mmio_input_port with DEBOUNCE_CYCLES=4. Reads push a
// hand-computed expected word into a scoreboard queue; a negedge monitor pops
// and compares whenever rd_valid is seen, and also checks response latency.
// ---------------------------------------------------------------------------
module tb_mmio_input_port;

  logic        clock;
  logic        rst;
  logic        btn_flap;
  logic        frame_start;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  typedef struct {
    logic [31:0] data;
    int          issue;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   pressCount = 0;
  int   lastPressCyc = -1;

  mmio_input_port #(
    .DEBOUNCE_CYCLES(4),
    .ID_VALUE       (32'hF1A9_0001)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .btn_flap   (btn_flap),
    .frame_start(frame_start),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one read; optionally pulse frame_start in the same cycle.
  task automatic applyStimulus(input string name, input logic [1:0] addr,
                               input logic [31:0] exp, input bit withFrame = 0);
    exp_t e;
    e.data  = exp;
    e.issue = cyc;
    e.name  = name;
    expQ.push_back(e);
    rd_en       = 1'b1;
    rd_addr     = addr;
    frame_start = withFrame;
    tick();
    rd_en       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: checks data and one-cycle latency, flags missing
  // or unexpected responses.
  always @(negedge clock) begin
    if (rd_valid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(e.name, rd_data, e.data);
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'd1);
      end
    end else if (expQ.size() > 0 && cyc >= expQ[0].issue + 1) begin
      exp_t e;
      e = expQ.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_missing: got rd_valid=0 expected 1 (cycle %0d)", e.name, cyc);
    end
  end

  // Press pulse observer on the debouncer output.
  always @(negedge clock) begin
    if (dut.u_debouncer.press) begin
      pressCount++;
      lastPressCyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c0;
    int pc;
    rst = 1'b1; btn_flap = 1'b0; frame_start = 1'b0; rd_en = 1'b0; rd_addr = 2'd0;
    tick(3);
    rst = 1'b0;
    tick();

    $display("[TB] test 1: reset values");
    applyStimulus("rst_status", 2'd0, 32'h0);
    applyStimulus("rst_frame",  2'd1, 32'h0);
    applyStimulus("rst_flaps",  2'd2, 32'h0);
    applyStimulus("rst_id",     2'd3, 32'hF1A9_0001);
    tick(2);

    $display("[TB] test 2: clean press");
    btn_flap = 1'b1;
    c0 = cyc;
    tick(20);
    checkOutput("press_count", 32'(pressCount), 32'd1);
    checkOutput("press_delay", 32'(lastPressCyc - c0), 32'd6);
    applyStimulus("press_status1", 2'd0, 32'h3);
    applyStimulus("press_status2", 2'd0, 32'h2);
    applyStimulus("press_flaps",   2'd2, 32'h1);
    btn_flap = 1'b0;
    tick(12);
    applyStimulus("release_status", 2'd0, 32'h0);
    tick(2);

    $display("[TB] test 3: bouncing button");
    doReset();
    pc = pressCount;
    for (int i = 0; i < 30; i++) begin
      btn_flap = (((i >> 1) & 1) == 0);
      tick();
    end
    btn_flap = 1'b0;
    tick(8);
    checkOutput("bounce_no_press", 32'(pressCount), 32'(pc));
    applyStimulus("bounce_status", 2'd0, 32'h0);
    applyStimulus("bounce_flaps",  2'd2, 32'h0);
    tick(2);

    $display("[TB] test 4: frame_start coincides with status read");
    applyStimulus("coinc_status1", 2'd0, 32'h0, 1'b1);
    applyStimulus("coinc_status2", 2'd0, 32'h4);
    applyStimulus("coinc_status3", 2'd0, 32'h0);
    applyStimulus("coinc_frame",   2'd1, 32'h1);
    tick(2);

    $display("[TB] test 5: counter boundaries");
    force dut.r_frame_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_frame_count;
    applyStimulus("frame_preload", 2'd1, 32'hFFFF_FFFF);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    applyStimulus("frame_wrap",   2'd1, 32'h0);
    applyStimulus("wrap_status",  2'd0, 32'h4);
    force dut.r_flap_count = 16'hFFFF;
    #1;
    release dut.r_flap_count;
    applyStimulus("flaps_preload", 2'd2, 32'h0000_FFFF);
    pc = pressCount;
    btn_flap = 1'b1;
    tick(12);
    checkOutput("sat_press", 32'(pressCount), 32'(pc + 1));
    applyStimulus("flaps_sat",  2'd2, 32'h0000_FFFF);
    applyStimulus("sat_status", 2'd0, 32'h3);
    btn_flap = 1'b0;
    tick(12);

    $display("[TB] test 6: reset during read and debounce");
    doReset();
    btn_flap = 1'b1;
    tick(4);
    pc = pressCount;
    rd_en   = 1'b1;
    rd_addr = 2'd0;
    tick();
    rd_en    = 1'b0;
    rst      = 1'b1;
    btn_flap = 1'b0;
    @(negedge clock);
    checkOutput("inflight_rd_valid", {31'b0, rd_valid}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(10);
    checkOutput("reset_no_press", 32'(pressCount), 32'(pc));
    applyStimulus("post_status", 2'd0, 32'h0);
    applyStimulus("post_frame",  2'd1, 32'h0);
    applyStimulus("post_flaps",  2'd2, 32'h0);
    applyStimulus("post_id",     2'd3, 32'hF1A9_0001);
    tick(3);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
